// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame geometry and parity polarity.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  // 1 selects odd overall parity: the parity bit makes the total count of ones odd.
  localparam logic PARITY_ODD         = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line and enable in, received byte and status out.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic                 en;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output rx, en,
    input  data, valid, parity_err, frame_err, busy
  );

  modport slave (
    input  rx, en,
    output data, valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic sync_reg [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= din;
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign dout = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 or 8O1 framing, mid-bit sampling from a start-edge-aligned baud counter.
// Results are registered and presented together with a one-cycle valid pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_rx_if.slave   bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_e          state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;
  logic                 rx_s;
  logic                 baud_done;
  logic                 half_done;

  uart_sync #(.STAGES(2)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.rx),
    .dout (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
    end
  end

  assign baud_done = (cnt_reg == BAUD_LAST);
  assign half_done = (cnt_reg == HALF_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    perr_next  = 1'b0;
    ferr_next  = 1'b0;

    // Dropping enable abandons any frame in flight; the last good byte stays on data.
    if (!bus.en) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      bit_next   = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (!rx_s) begin
            state_next = ST_START;
            cnt_next   = '0;
            bit_next   = '0;
          end
        end

        ST_START: begin
          if (half_done) begin
            cnt_next   = '0;
            state_next = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end

        ST_DATA: begin
          if (baud_done) begin
            cnt_next   = '0;
            shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_next   = bit_reg + BW'(1);
            if (bit_reg == BIT_LAST)
              state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end

        ST_PARITY: begin
          if (baud_done) begin
            cnt_next   = '0;
            par_next   = rx_s;
            state_next = ST_STOP;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end

        // Bad frames are still delivered; the flags tell the consumer what went wrong.
        ST_STOP: begin
          if (baud_done) begin
            cnt_next   = '0;
            data_next  = shift_reg;
            valid_next = 1'b1;
            perr_next  = (PARITY_EN != 0) && (par_reg != calc_parity(shift_reg));
            ferr_next  = !rx_s;
            state_next = rx_s ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end

        ST_WAIT_IDLE: begin
          if (rx_s) state_next = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          bit_next   = '0;
        end
      endcase
    end
  end

  assign bus.data       = data_reg;
  assign bus.valid      = valid_reg;
  assign bus.parity_err = perr_reg;
  assign bus.frame_err  = ferr_reg;
  assign bus.busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: each sent frame queues its expected result,
// which is popped and compared when the receiver pulses valid.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(C), .PARITY_EN(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   checks    = 0;
  int   failures  = 0;
  int   vcount    = 0;
  int   flag_viol = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid) begin
        vcount++;
        $display("RX  t=%0t data=%02h parity_err=%0b frame_err=%0b",
                 $time, bus.data, bus.parity_err, bus.frame_err);
        check_eq("valid_expected", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check_eq("data", {24'd0, bus.data}, {24'd0, mon_e.d});
          check_eq("parity_err", {31'd0, bus.parity_err}, {31'd0, mon_e.pe});
          check_eq("frame_err", {31'd0, bus.frame_err}, {31'd0, mon_e.fe});
        end
      end else if (bus.parity_err || bus.frame_err) begin
        flag_viol++;
      end
    end
  end

  // Bits go out LSB first, each held for C clocks; call on a falling edge.
  task automatic drive_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx = bits[i];
      repeat (C) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_bit);
    logic par;
    exp_t e;
    par  = ~(^d) ^ bad_par;
    e.d  = d;
    e.pe = bad_par;
    e.fe = ~stop_bit;
    sb_q.push_back(e);
    $display("TX  t=%0t data=%02h parity=%0b stop=%0b", $time, d, par, stop_bit);
    drive_bits({stop_bit, par, d, 1'b0}, 11);
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) @(negedge clk);
    check_eq(tag, sb_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx = 1'b1;
    bus.en = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_data", {24'd0, bus.data}, 32'h00);
    check_eq("rst_valid", {31'd0, bus.valid}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
    check_eq("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean frame
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_drain("drain_a5", 50);
    repeat (C) @(negedge clk);

    // Wrong parity bit
    send_frame(8'h01, 1'b1, 1'b1);
    wait_drain("drain_01", 50);
    repeat (C) @(negedge clk);

    // Missing stop bit, line held low afterwards
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_drain("drain_3c", 50);
    repeat (20) @(negedge clk);
    check_eq("busy_wait_idle_mid", {31'd0, bus.busy}, 32'd1);
    repeat (20) @(negedge clk);
    check_eq("busy_wait_idle_end", {31'd0, bus.busy}, 32'd1);
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("busy_after_recovery", {31'd0, bus.busy}, 32'd0);
    repeat (C) @(negedge clk);

    // Short low glitch on an idle line
    bus.rx = 1'b0;
    repeat (5) @(negedge clk);
    bus.rx = 1'b1;
    repeat (7) @(negedge clk);
    check_eq("glitch_busy_cleared", {31'd0, bus.busy}, 32'd0);
    repeat (C) @(negedge clk);

    // Back-to-back frames with no idle gap
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    wait_drain("drain_b2b", 50);
    repeat (C) @(negedge clk);

    // Enable dropped mid-frame
    drive_bits({7'h7F, 3'b100, 1'b0}, 4);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("abort_data_held", {24'd0, bus.data}, 32'hAA);
    bus.rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    bus.en = 1'b1;
    repeat (C) @(negedge clk);

    // Reset after the 4th data bit of 0x7E, then a full 0x7E
    drive_bits({6'h3F, 4'b1110, 1'b0}, 5);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midreset_data", {24'd0, bus.data}, 32'h00);
    check_eq("midreset_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    repeat (C) @(negedge clk);
    send_frame(8'h7E, 1'b0, 1'b1);
    wait_drain("drain_7e", 50);
    repeat (2 * C) @(negedge clk);

    check_eq("scoreboard_empty", sb_q.size(), 0);
    check_eq("valid_count", vcount, 6);
    check_eq("flags_without_valid", flag_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal values are >= 4.
REQ-002 The module SHALL have parameter PARITY_EN, default 1, meaning the parity bit is present (1) or absent (0).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 The module SHALL have port en, input, 1, receive enable.
REQ-007 The module SHALL have port data, output, 8, last received byte.
REQ-008 The module SHALL have port valid, output, 1, one-cycle pulse when data is updated.
REQ-009 The module SHALL have port parity_err, output, 1, parity mismatch flag, qualified by valid.
REQ-010 The module SHALL have port frame_err, output, 1, stop bit sampled low, qualified by valid.
REQ-011 The module SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 The frame SHALL be: start (0), 8 data bits LSB first, parity bit if PARITY_EN, stop (1).
REQ-013 Expected parity SHALL be 1 when data has an even number of ones and 0 when odd (odd overall parity).
REQ-014 rx SHALL pass through a 2-flop synchronizer before any use; the 2-cycle latency is accepted.
REQ-015 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-016 IDLE SHALL go to START when en=1 and synchronized rx=0; the bit counter is cleared on entry.
REQ-017 START SHALL wait floor(CLKS_PER_BIT/2) cycles and then resample: a 0 goes to DATA, a 1 (glitch) returns to IDLE with no flags.
REQ-018 DATA SHALL sample every CLKS_PER_BIT cycles, 8 samples, shifting into bit index 0..7.
REQ-019 After the 8th sample, DATA SHALL go to PARITY if PARITY_EN, else to STOP.
REQ-020 PARITY SHALL sample once after CLKS_PER_BIT cycles.
REQ-021 STOP SHALL sample after CLKS_PER_BIT cycles. On the next cycle it updates data, pulses valid for 1 cycle, and sets parity_err and frame_err for that same cycle.
REQ-022 After STOP, the FSM SHALL go to IDLE if the stop sample was 1, else to WAIT_IDLE.
REQ-023 WAIT_IDLE SHALL hold until synchronized rx=1 (break or framing recovery), then go to IDLE.
REQ-024 Back-to-back frames SHALL be accepted: a start edge is detectable in the first IDLE cycle after STOP.
REQ-025 en=0 in any state SHALL abort to IDLE on the next edge with no valid pulse; data is held.
REQ-026 data SHALL hold its value between valid pulses; parity_err and frame_err SHALL be 0 whenever valid=0.
REQ-027 A frame with a parity or framing error SHALL still update data and pulse valid.
REQ-028 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: state IDLE, data 8'h00, valid 0, parity_err 0, frame_err 0, busy 0, synchronizer flops 1, counters 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial byte; reception resumes only on a new start edge after rst_n deasserts.

Structure
REQ-031 Package uart_pkg SHALL hold the state encoding, DATA_BITS=8, the parity polarity constant, and the default CLKS_PER_BIT; it is shared with the transmitter.
REQ-032 The 2-flop synchronizer SHALL be the single sub-module uart_sync, with reset value 1.

Verification
REQ-033 With CLKS_PER_BIT=16 and frame 0xA5 with parity 1 and stop 1, valid SHALL pulse once with data=0xA5 and both errors 0.
REQ-034 Frame 0x01 with parity bit 1 (wrong) SHALL give valid with data=0x01 and parity_err=1.
REQ-035 Frame 0x3C with stop=0 and rx then held low 40 cycles SHALL give frame_err=1, busy held through WAIT_IDLE, and no second valid until rx returns high.
REQ-036 A 5-cycle low glitch on idle rx SHALL produce no valid, and busy SHALL return to 0 by cycle 12.
REQ-037 Frames 0x55 and 0xAA back-to-back with no idle gap SHALL give exactly 2 valid pulses in order.
REQ-038 Driving rst_n low after the 4th data bit, then sending 0x7E, SHALL give data=0x00 after reset and a single valid with data=0x7E.
